// File: rtl/io_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// io_port_arbiter_pkg
//   Shared definitions for the I/O write-port arbiter: the two-state FSM
//   encoding and the helper that derives the grant-index width from the
//   number of requesters.
// ---------------------------------------------------------------------------
package io_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_t;

    // Width of an index able to name every requester (at least one bit).
    function automatic int id_width_for(input int count);
        if (count <= 2) begin
            id_width_for = 1;
        end else begin
            id_width_for = $clog2(count);
        end
    endfunction

endpackage

// File: rtl/io_port_arbiter_rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
//   Combinational round-robin selector. Finds the first set request bit at or
//   above the pointer, wrapping modulo REQ_COUNT.
// Ports:
//   req        in   REQ_COUNT   eligible request vector
//   ptr        in   ID_WIDTH    highest-priority index
//   grant      out  ID_WIDTH    selected index (valid when any_grant)
//   any_grant  out  1           at least one request bit set
// ---------------------------------------------------------------------------
module rr_priority_select
    import io_port_arbiter_pkg::*;
#(
    parameter int REQ_COUNT = 4,
    parameter int ID_WIDTH  = 2
) (
    input  logic [REQ_COUNT-1:0] req,
    input  logic [ID_WIDTH-1:0]  ptr,
    output logic [ID_WIDTH-1:0]  grant,
    output logic                 any_grant
);

    logic [2*REQ_COUNT-1:0] dbl_s;
    logic [REQ_COUNT-1:0]   rot_s;
    logic [ID_WIDTH-1:0]    off_s;
    logic [ID_WIDTH:0]      sum_s;
    logic [ID_WIDTH:0]      wrap_s;

    // Rotate so the pointer position lands at bit 0, then take the lowest
    // set bit as an offset from the pointer.
    always_comb begin
        dbl_s = {req, req} >> ptr;
        rot_s = dbl_s[REQ_COUNT-1:0];
        off_s = {ID_WIDTH{1'b0}};
        // Scan downwards so the lowest set bit is the one that sticks.
        for (int i = REQ_COUNT - 1; i >= 0; i--) begin
            off_s = rot_s[i] ? ID_WIDTH'(i) : off_s;
        end
    end

    // Map the offset back to an absolute requester index modulo REQ_COUNT.
    always_comb begin
        sum_s = {1'b0, ptr} + {1'b0, off_s};
        if (sum_s >= (ID_WIDTH + 1)'(REQ_COUNT)) begin
            wrap_s = sum_s - (ID_WIDTH + 1)'(REQ_COUNT);
        end else begin
            wrap_s = sum_s;
        end
        grant     = wrap_s[ID_WIDTH-1:0];
        any_grant = |req;
    end

endmodule

// File: rtl/io_port_arbiter.sv
// ---------------------------------------------------------------------------
// io_port_arbiter
//   Shares one external I/O write device among REQ_COUNT requesters using
//   round-robin arbitration and a registered valid/ready handshake. A
//   one-cycle req_done pulse tells the winning requester its word was taken.
// Ports:
//   clock       in   1                     rising-edge clock
//   reset       in   1                     asynchronous active-high reset
//   req         in   REQ_COUNT             level requests, held until done
//   req_enable  in   REQ_COUNT             per-requester arbitration mask
//   req_data    in   REQ_COUNT*WORD_WIDTH  requester i data at [i*W +: W]
//   req_done    out  REQ_COUNT             one-hot done pulse
//   dev_valid   out  1                     dev_data valid toward device
//   dev_data    out  WORD_WIDTH            registered granted data
//   dev_ready   in   1                     device accept
//   grant_id    out  ID_WIDTH              current / last granted index
//   busy        out  1                     high while sending
// ---------------------------------------------------------------------------
module io_port_arbiter
    import io_port_arbiter_pkg::*;
#(
    parameter int REQ_COUNT  = 4,
    parameter int WORD_WIDTH = 36,
    parameter int ID_WIDTH   = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [REQ_COUNT-1:0]            req,
    input  logic [REQ_COUNT-1:0]            req_enable,
    input  logic [REQ_COUNT*WORD_WIDTH-1:0] req_data,
    output logic [REQ_COUNT-1:0]            req_done,
    output logic                            dev_valid,
    output logic [WORD_WIDTH-1:0]           dev_data,
    input  logic                            dev_ready,
    output logic [ID_WIDTH-1:0]             grant_id,
    output logic                            busy
);

    if (ID_WIDTH != id_width_for(REQ_COUNT)) begin : g_bad_id_width
        $error("io_port_arbiter: ID_WIDTH does not match REQ_COUNT");
    end

    arb_state_t              state_r;
    logic [ID_WIDTH-1:0]     ptr_r;
    logic [REQ_COUNT-1:0]    eligible_s;
    logic [ID_WIDTH-1:0]     sel_id_s;
    logic                    any_s;
    logic [WORD_WIDTH-1:0]   sel_data_s;
    logic [ID_WIDTH-1:0]     ptr_next_s;
    logic [REQ_COUNT-1:0]    done_vec_s;

    assign eligible_s = req & req_enable;

    rr_priority_select #(
        .REQ_COUNT (REQ_COUNT),
        .ID_WIDTH  (ID_WIDTH)
    ) u_select (
        .req       (eligible_s),
        .ptr       (ptr_r),
        .grant     (sel_id_s),
        .any_grant (any_s)
    );

    // Data word of the requester the selector picked.
    always_comb begin
        sel_data_s = {WORD_WIDTH{1'b0}};
        for (int i = 0; i < REQ_COUNT; i++) begin
            sel_data_s = (sel_id_s == ID_WIDTH'(i)) ?
                         req_data[i*WORD_WIDTH +: WORD_WIDTH] : sel_data_s;
        end
    end

    // Pointer moves just past the requester being completed, and its done bit.
    always_comb begin
        if (grant_id == ID_WIDTH'(REQ_COUNT - 1)) begin
            ptr_next_s = {ID_WIDTH{1'b0}};
        end else begin
            ptr_next_s = grant_id + ID_WIDTH'(1);
        end
        done_vec_s = {{(REQ_COUNT-1){1'b0}}, 1'b1} << grant_id;
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ptr_r     <= {ID_WIDTH{1'b0}};
            dev_valid <= 1'b0;
            dev_data  <= {WORD_WIDTH{1'b0}};
            grant_id  <= {ID_WIDTH{1'b0}};
            req_done  <= {REQ_COUNT{1'b0}};
            busy      <= 1'b0;
        end else begin
            // Done is a single-cycle pulse unless the handshake sets it below.
            req_done <= {REQ_COUNT{1'b0}};
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        dev_data  <= sel_data_s;
                        grant_id  <= sel_id_s;
                        dev_valid <= 1'b1;
                        busy      <= 1'b1;
                        state_r   <= ST_SEND;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    // Requests are not re-sampled here; the transfer always completes.
                    if (dev_ready) begin
                        req_done  <= done_vec_s;
                        ptr_r     <= ptr_next_s;
                        dev_valid <= 1'b0;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= ST_SEND;
                    end
                end
                default: begin
                    dev_valid <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_io_port_arbiter
//   Directed scenarios followed by a randomized run, all compared against a
//   transaction-level reference model of the round-robin arbiter.
// ---------------------------------------------------------------------------
module tb_io_port_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    req_enable;
    logic [N*W-1:0]  req_data;
    logic [N-1:0]    req_done;
    logic            dev_valid;
    logic [W-1:0]    dev_data;
    logic            dev_ready;
    logic [IW-1:0]   grant_id;
    logic            busy;

    io_port_arbiter #(
        .REQ_COUNT  (N),
        .WORD_WIDTH (W),
        .ID_WIDTH   (IW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_enable (req_enable),
        .req_data   (req_data),
        .req_done   (req_done),
        .dev_valid  (dev_valid),
        .dev_data   (dev_data),
        .dev_ready  (dev_ready),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // Reference model: a transfer in flight or not, who owns it, rotation pointer.
    bit        m_sending;
    int        m_owner;
    int        m_ptr;
    logic [7:0] m_word;
    logic [3:0] m_done;

    int  grants[$];
    int  grant_cyc[$];
    int  cyc_n = 0;
    bit  prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] word_of(input int i);
        return req_data[i*8 +: 8];
    endfunction

    task automatic model_reset();
        m_sending = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_word    = 8'h00;
        m_done    = 4'b0000;
    endtask

    // One clock edge of the arbiter's contract, from current inputs.
    task automatic model_step();
        logic [3:0] elig;
        m_done = 4'b0000;
        if (!m_sending) begin
            elig = req & req_enable;
            for (int k = 0; k < N; k++) begin
                if (!m_sending && elig[(m_ptr + k) % N]) begin
                    m_owner   = (m_ptr + k) % N;
                    m_word    = word_of(m_owner);
                    m_sending = 1'b1;
                end
            end
        end else if (dev_ready) begin
            m_done    = 4'b0001 << m_owner;
            m_ptr     = (m_owner + 1) % N;
            m_sending = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".dev_valid"}, 64'(dev_valid), 64'(m_sending));
        chk({tag, ".busy"},      64'(busy),      64'(m_sending));
        chk({tag, ".dev_data"},  64'(dev_data),  64'(m_word));
        chk({tag, ".grant_id"},  64'(grant_id),  64'(m_owner));
        chk({tag, ".req_done"},  64'(req_done),  64'(m_done));
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_step();
        #1;
        check_outputs(tag);
        if (dev_valid && !prev_valid) begin
            grants.push_back(int'(grant_id));
            grant_cyc.push_back(cyc_n);
        end
        prev_valid = dev_valid;
        cyc_n++;
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    task automatic expect_grants(input string tag, input int exp[$]);
        chk({tag, ".count"}, 64'(grants.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < grants.size()) chk($sformatf("%s.g%0d", tag, i), 64'(grants[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        req        = 4'b0000;
        req_enable = 4'b1111;
        req_data   = 32'h0;
        dev_ready  = 1'b0;
        reset      = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        check_outputs("reset");

        // 1. Reset in the middle of a stalled transfer.
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req      = 4'b0001;
        run("t1.pre", 2);
        chk("t1.in_send", 64'(dev_valid), 64'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        chk("t1.async_valid", 64'(dev_valid), 64'(1'b0));
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
        req   = 4'b0000;
        prev_valid = 1'b0;
        check_outputs("t1.after");
        run("t1.idle", 2);

        // 3. All requesters held high: pointer restarts at 0 and rotates.
        grants.delete();
        grant_cyc.delete();
        req       = 4'b1111;
        dev_ready = 1'b1;
        run("t3", 10);
        expect_grants("t3.order", '{0, 1, 2, 3, 0});
        for (int i = 1; i < grant_cyc.size(); i++)
            chk($sformatf("t3.spacing%0d", i), 64'(grant_cyc[i] - grant_cyc[i-1]), 64'd2);
        req = 4'b0000;
        run("t3.drain", 2);

        // 2. Single requester 1 with an always-ready device.
        req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
        req      = 4'b0010;
        cycle("t2.grant");
        chk("t2.valid", 64'(dev_valid), 64'(1'b1));
        chk("t2.data",  64'(dev_data),  64'(8'hA5));
        chk("t2.id",    64'(grant_id),  64'(2'd1));
        cycle("t2.done");
        chk("t2.req_done", 64'(req_done), 64'(4'b0010));
        req = 4'b0000;
        run("t2.idle", 2);

        // 4. Masked requester waits until enabled, then goes next.
        grants.delete();
        req        = 4'b0101;
        req_enable = 4'b0001;
        run("t4.masked", 6);
        expect_grants("t4.only0", '{0, 0, 0});
        grants.delete();
        req_enable = 4'b0101;
        run("t4.unmasked", 2);
        expect_grants("t4.next2", '{2});
        req        = 4'b0000;
        req_enable = 4'b1111;
        run("t4.drain", 2);

        // 5. Stalled device; requester drops req mid-transfer.
        req_data  = {8'h44, 8'h33, 8'h22, 8'h5C};
        req       = 4'b0001;
        dev_ready = 1'b0;
        cycle("t5.grant");
        for (int i = 0; i < 5; i++) begin
            if (i == 2) req = 4'b0000;
            cycle("t5.stall");
            chk("t5.data_stable", 64'(dev_data), 64'(8'h5C));
            chk("t5.valid_held",  64'(dev_valid), 64'(1'b1));
        end
        dev_ready = 1'b1;
        cycle("t5.accept");
        chk("t5.req_done", 64'(req_done), 64'(4'b0001));
        run("t5.drain", 2);

        // 6. Wrap-around from requester 3 back to 0.
        grants.delete();
        req = 4'b1000;
        run("t6.first", 2);
        req = 4'b1001;
        run("t6.pair", 4);
        req = 4'b0000;
        run("t6.drain", 1);
        expect_grants("t6.order", '{3, 0, 3});
        run("t6.idle", 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req        = 4'($urandom_range(0, 15));
            req_enable = 4'($urandom_range(0, 15));
            req_data   = $urandom;
            dev_ready  = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
